dmem_responder: RTL and testbench

//   Data-memory responder for the pipeline's memory stage. Accepts one load or

---
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the memory stage. It takes one load or store at
//   a time on a valid/ready request channel and waits WAIT_CYCLES wait states.
//   It then accesses the word array and returns read data or a write
//   acknowledge on a valid/ready response channel.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   req_valid  request present
//   req_ready  request can be accepted this cycle (registered, high only in IDLE)
//   req_we     1 = store, 0 = load
//   req_addr   byte address, word index = req_addr[31:2]
//   req_wdata  store data
//   req_be     store byte enables, be[i] -> bits 8i+7:8i
//   rsp_valid  response present (registered)
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data, 0 for stores and faults
//   rsp_err    misaligned or out-of-range access
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  l_be;

    logic [31:0] mem [DEPTH_WORDS];

    // Any address bit above the array range faults; nothing is wrapped.
    logic          acc_err;
    logic [AW-1:0] widx;
    assign acc_err = (l_addr[1:0] != 2'b00) | (|l_addr[31:AW+2]);
    assign widx    = l_addr[AW+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            l_we      <= 1'b0;
            l_addr    <= 32'd0;
            l_wdata   <= 32'd0;
            l_be      <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        l_we      <= req_we;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        l_be      <= req_be;
                        cnt       <= WAIT_CYCLES[3:0];
                        req_ready <= 1'b0;
                        state     <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_ACCESS;
                end
                S_ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= acc_err;
                    rsp_rdata <= (!l_we && !acc_err) ? mem[widx] : 32'd0;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The array is never reset. Reset forces state to IDLE asynchronously, so
    // a store caught in flight never reaches this write.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && l_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (l_be[i]) mem[widx][8*i +: 8] <= l_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH  = 256;
    localparam int DEPTHB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;

    logic        req_valid = 0, req_we = 0, rsp_ready = 1;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_be = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid = 0, b_req_we = 0, b_rsp_ready = 1;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0;
    logic [3:0]  b_req_be = 0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic [31:0] model  [int];
    logic [31:0] modelb [int];
    logic [31:0] exp_d_q [$];
    logic        exp_e_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTHB), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    function automatic logic addr_err(input logic [31:0] a, input int depth);
        return (a[1:0] != 2'b00) || ((a >> 2) >= depth);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Drive one request starting at a negedge. Returns the cycle whose closing
    // edge accepted it and leaves the caller at the following negedge.
    task automatic send_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, output int acc);
        int n = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        while (!req_ready && n < 60) begin @(negedge clk); n++; end
        if (!req_ready) begin
            total++;
            $display("FAIL req_accept_timeout req_ready=%b required=1", req_ready);
        end
        acc = cyc;
        @(negedge clk);
        req_valid = 0;
    endtask

    // Scoreboarded request: expected response is computed and queued here.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output int acc);
        logic        e;
        logic [31:0] d;
        int          idx;
        e = addr_err(a, DEPTH);
        idx = int'(a >> 2);
        d = 32'd0;
        if (!e && we) model[idx] = merge(model.exists(idx) ? model[idx] : 32'hx, wd, be);
        if (!e && !we) d = model[idx];
        exp_d_q.push_back(d);
        exp_e_q.push_back(e);
        send_req(we, a, wd, be, acc);
    endtask

    // Wait (bounded) for rsp_valid at negedges; consume it if rsp_ready is high.
    task automatic wait_rsp(output logic [31:0] d, output logic e, output int c);
        int n = 0;
        while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            total++;
            $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
        end
        d = rsp_rdata; e = rsp_err; c = cyc;
        if (rsp_ready) @(negedge clk);
    endtask

    task automatic test_reset;
        total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b exp=1", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        total++; if (rsp_rdata !== 32'd0) $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); else passed++;
        total++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); else passed++;
    endtask

    task automatic test_reset_midwait;
        logic [31:0] d, ed; logic e, ee; int acc, c;
        issue(1, 32'h10, 32'h12345678, 4'hF, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (e !== ee) $display("FAIL rst_pre_store_err got=%b exp=%b", e, ee); else passed++;
        // Dropped store: not entered in the model or scoreboard.
        send_req(1, 32'h10, 32'hFFFF_FFFF, 4'hF, acc);
        rst = 0;
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL midwait_req_ready got=%b exp=1", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL midwait_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        @(negedge clk); @(negedge clk);
        rst = 1;
        @(negedge clk);
        issue(0, 32'h10, 0, 4'h0, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (d !== ed) $display("FAIL midwait_reload got=%h exp=%h", d, ed); else passed++;
    endtask

    task automatic test_store_load;
        logic [31:0] d, ed; logic e, ee; int acc, c;
        issue(1, 32'h40, 32'hDEADBEEF, 4'hF, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (c - acc !== 4) $display("FAIL st_latency got=%0d exp=4", c - acc); else passed++;
        total++; if (d !== ed || e !== ee) $display("FAIL st_ack got=%h/%b exp=%h/%b", d, e, ed, ee); else passed++;
        issue(0, 32'h40, 0, 4'h0, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (c - acc !== 4) $display("FAIL ld_latency got=%0d exp=4", c - acc); else passed++;
        total++; if (d !== ed) $display("FAIL ld_data got=%h exp=%h", d, ed); else passed++;
        total++; if (e !== ee) $display("FAIL ld_err got=%b exp=%b", e, ee); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL ld_rsp_drop got=%b exp=0", rsp_valid); else passed++;
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d, ed; logic e, ee; int acc, c;
        issue(1, 32'h44, 32'h11223344, 4'hF, acc);
        wait_rsp(d, e, c); void'(exp_d_q.pop_front()); void'(exp_e_q.pop_front());
        issue(1, 32'h44, 32'hAABBCCDD, 4'b0101, acc);
        wait_rsp(d, e, c); void'(exp_d_q.pop_front()); void'(exp_e_q.pop_front());
        issue(0, 32'h44, 0, 4'h0, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (d !== 32'h11BB33DD || d !== ed) $display("FAIL be_merge got=%h exp=%h", d, ed); else passed++;
        issue(1, 32'h44, 32'h0, 4'b0000, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (e !== ee) $display("FAIL be_zero_err got=%b exp=%b", e, ee); else passed++;
        issue(0, 32'h44, 0, 4'h0, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (d !== ed) $display("FAIL be_zero_data got=%h exp=%h", d, ed); else passed++;
    endtask

    task automatic test_faults;
        logic [31:0] d, ed; logic e, ee; int acc, c;
        issue(1, 32'h0, 32'hCAFEF00D, 4'hF, acc);
        wait_rsp(d, e, c); void'(exp_d_q.pop_front()); void'(exp_e_q.pop_front());
        issue(0, 32'h42, 0, 4'h0, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (e !== ee || ee !== 1'b1) $display("FAIL misalign_err got=%b exp=%b", e, ee); else passed++;
        total++; if (d !== ed) $display("FAIL misalign_data got=%h exp=%h", d, ed); else passed++;
        issue(1, 32'(4 * DEPTH), 32'h99999999, 4'hF, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (e !== ee) $display("FAIL range_err got=%b exp=%b", e, ee); else passed++;
        issue(0, 32'h0, 0, 4'h0, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (d !== ed) $display("FAIL range_word0 got=%h exp=%h", d, ed); else passed++;
    endtask

    task automatic test_backpressure;
        logic [31:0] d, ed; logic e, ee; int acc, c;
        issue(1, 32'h48, 32'h01020304, 4'hF, acc);
        wait_rsp(d, e, c); void'(exp_d_q.pop_front()); void'(exp_e_q.pop_front());
        rsp_ready = 0;
        issue(0, 32'h40, 0, 4'h0, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            // Stray stores that must be ignored while busy.
            req_valid = i[0]; req_we = 1; req_addr = 32'h48; req_wdata = 32'h55AA55AA; req_be = 4'hF;
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== ed || req_ready !== 1'b0)
                $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/%h/0", i, rsp_valid, rsp_rdata, req_ready, ed);
            else passed++;
        end
        req_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) $display("FAIL bp_release got=%b/%h exp=0/0", rsp_valid, rsp_rdata); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL bp_idle_ready got=%b exp=1", req_ready); else passed++;
        issue(0, 32'h48, 0, 4'h0, acc);
        wait_rsp(d, e, c);
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        total++; if (d !== ed) $display("FAIL bp_ignored_store got=%h exp=%h", d, ed); else passed++;
    endtask

    task automatic test_back_to_back_wait0;
        logic        we_t [6] = '{1, 1, 1, 0, 0, 0};
        logic [31:0] a_t  [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h0, 32'h4};
        logic [31:0] wd_t [6] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 0, 0, 0};
        logic [31:0] qd [$];
        int          qa [$];
        int          idx = 0, nrsp = 0, last_acc = -1;
        logic        adv = 0;
        b_req_valid = 1; b_req_we = we_t[0]; b_req_addr = a_t[0]; b_req_wdata = wd_t[0]; b_req_be = 4'hF;
        for (int k = 0; k < 30; k++) begin
            if (adv) begin
                adv = 0;
                if (idx < 6) begin
                    b_req_we = we_t[idx]; b_req_addr = a_t[idx]; b_req_wdata = wd_t[idx];
                end else b_req_valid = 0;
            end
            if (b_rsp_valid) begin
                if (qd.size() == 0) begin
                    total++; $display("FAIL w0_unexpected_rsp rsp_valid=%b required=0", b_rsp_valid);
                end else begin
                    logic [31:0] ed; int ea;
                    ed = qd.pop_front(); ea = qa.pop_front();
                    total++; if (cyc - ea !== 2) $display("FAIL w0_latency got=%0d exp=2", cyc - ea); else passed++;
                    total++; if (b_rsp_rdata !== ed || b_rsp_err !== 1'b0) $display("FAIL w0_data got=%h/%b exp=%h/0", b_rsp_rdata, b_rsp_err, ed); else passed++;
                    nrsp++;
                end
            end
            if (b_req_valid && b_req_ready) begin
                int wi;
                wi = int'(b_req_addr >> 2);
                if (b_req_we) begin
                    modelb[wi] = b_req_wdata;
                    qd.push_back(32'd0);
                end else qd.push_back(modelb[wi]);
                qa.push_back(cyc);
                if (last_acc >= 0) begin
                    total++; if (cyc - last_acc !== 3) $display("FAIL w0_spacing got=%0d exp=3", cyc - last_acc); else passed++;
                end
                last_acc = cyc;
                idx++;
                adv = 1;
            end
            @(negedge clk);
        end
        b_req_valid = 0;
        total++; if (nrsp !== 6) $display("FAIL w0_rsp_count got=%0d exp=6", nrsp); else passed++;
    endtask

    initial begin
        rst = 0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1;
        @(negedge clk);
        test_store_load;
        test_byte_lanes;
        test_faults;
        test_backpressure;
        test_reset_midwait;
        test_back_to_back_wait0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule
